// File: rtl/register_write_queue.sv
// Circular write-back queue that merges load and ALU results into one register-file
// write port. Pending entries and the write-back register are visible to combinational bypass.
module register_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         memValid,
  input  logic [4:0]                   memReg,
  input  logic [31:0]                  memData,
  output logic                         memReady,
  input  logic                         aluValid,
  input  logic [4:0]                   aluReg,
  input  logic [31:0]                  aluData,
  output logic                         aluReady,
  output logic                         regWrite,
  output logic [4:0]                   writeRegister,
  output logic [31:0]                  writeData,
  input  logic [4:0]                   lookupReg1,
  input  logic [4:0]                   lookupReg2,
  output logic                         hit1,
  output logic                         hit2,
  output logic [31:0]                  bypassData1,
  output logic [31:0]                  bypassData2,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] alu_slot;
  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic          mem_take;
  logic          alu_take;
  logic          pop;

  // Handshake: a request transfers on a cycle where valid and ready are both high;
  // ready never depends on the same-cycle pop. Destination 0 transfers but is dropped.
  assign memReady = count < CW'(DEPTH);
  assign mem_take = memValid & memReady & (memReg != 5'd0);
  assign aluReady = (count + CW'(mem_take)) < CW'(DEPTH);
  assign alu_take = aluValid & aluReady & (aluReg != 5'd0);
  assign pop      = (count != '0);
  assign alu_slot = tail + PW'(mem_take);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      regWrite <= pop;
      if (pop) begin
        writeRegister <= reg_mem[head];
        writeData     <= data_mem[head];
        head          <= head + 1'b1;
      end
      tail  <= tail + PW'(mem_take) + PW'(alu_take);
      count <= count + CW'(mem_take) + CW'(alu_take) - CW'(pop);
    end
  end

  // Mem is the older result, so it takes the tail slot ahead of the ALU entry.
  always_ff @(posedge clk) begin
    if (mem_take) begin
      reg_mem[tail]  <= memReg;
      data_mem[tail] <= memData;
    end
    if (alu_take) begin
      reg_mem[alu_slot]  <= aluReg;
      data_mem[alu_slot] <= aluData;
    end
  end

  // Returns {hit, data}; walking oldest to youngest lets the youngest match win.
  function automatic logic [32:0] lookup(input logic [4:0] lk);
    logic [32:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    if (lk != 5'd0) begin
      if (regWrite && (writeRegister == lk)) res = {1'b1, writeData};
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PW'(k);
        if ((CW'(k) < count) && (reg_mem[idx] == lk)) res = {1'b1, data_mem[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {hit1, bypassData1} = lookup(lookupReg1);
    {hit2, bypassData2} = lookup(lookupReg2);
  end
endmodule
